list_builder: RTL and testbench
===============================

LIST_BUILDER -- requirements
Module: list_builder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, the block-RAM address width; list capacity is CAP = 2^(ADDR_W-1) elements.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: a single-cycle pulse that begins building a new list.
REQ-005 SHALL have port in_valid, input, 1 bit: the producer has an element on in_data.
REQ-006 SHALL have port in_data, input, 32 bits: the element data value.
REQ-007 SHALL have port in_last, input, 1 bit: the current element is the final list element.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts an element this cycle.
REQ-009 SHALL have port wr_en, output, 1 bit: block-RAM write enable.
REQ-010 SHALL have port ram_addr, output, ADDR_W bits: block-RAM address.
REQ-011 SHALL have port ram_din, output, 32 bits: block-RAM write data.
REQ-012 SHALL have port done, output, 1 bit: the list is complete and terminated.
REQ-013 SHALL have port full, output, 1 bit: the list was truncated at capacity.
REQ-014 SHALL have port elem_count, output, ADDR_W bits: the number of elements written.

Function
REQ-015 SHALL write the list in the accumulator's format: element k data at address 2k, element k next-pointer at address 2k+1, with the head at address 0.
REQ-016 SHALL write a next-pointer of 2k+2 (zero-extended to 32 bits) for a non-final element and 0 for the terminating element.
REQ-017 SHALL implement FSM states IDLE, ACCEPT, WR_DATA, WR_PTR and DONE.
REQ-018 SHALL, in IDLE or DONE with start=1, go to ACCEPT, clear k, elem_count, done and full; start SHALL be ignored in all other states.
REQ-019 SHALL drive in_ready=1 only in ACCEPT; a transfer occurs when in_valid and in_ready are both 1, which latches in_data and in_last and moves to WR_DATA.
REQ-020 SHALL hold ACCEPT indefinitely while in_valid=0; in_data and in_last are ignored when no transfer occurs.
REQ-021 SHALL, in WR_DATA, drive wr_en=1, ram_addr=2k and ram_din=latched data for exactly one cycle, then go to WR_PTR.
REQ-022 SHALL, in WR_PTR, drive wr_en=1 and ram_addr=2k+1 with the pointer from REQ-016, increment elem_count, and then go to one of two states:
- DONE if the element is terminal;
- otherwise ACCEPT with k incremented.
REQ-023 SHALL treat an element as terminal when latched in_last=1 or k=CAP-1.
REQ-024 SHALL set full=1 when k=CAP-1 and latched in_last=0.
REQ-025 SHALL drive wr_en=0 in IDLE, ACCEPT and DONE, and ram_addr/ram_din SHALL be don't-care whenever wr_en=0.
REQ-026 SHALL hold done=1 in DONE until the next start or reset; full and elem_count SHALL also hold in DONE.
REQ-027 SHALL have a maximum throughput of one element per 3 cycles, with latency from transfer to pointer write of 2 cycles.
REQ-028 SHALL compute addresses modulo 2^ADDR_W; k never exceeds CAP-1, so no wrap occurs.

Reset
REQ-029 SHALL, with rst=0 at a clock edge, enter IDLE; in_ready, wr_en, done and full SHALL be 0, elem_count 0, k 0.
REQ-030 SHALL, on reset mid-list, abandon the partial list with no further writes from the next cycle; the unterminated RAM contents SHALL be left as is.
REQ-031 SHALL give reset priority over start and any transfer in the same cycle.

Verification
REQ-032 Data 5, 7, 9 with in_last on 9 -> writes (0,5), (1,2), (2,7), (3,4), (4,9), (5,0); then done=1, elem_count=3, full=0.
REQ-033 A single element 0xDEADBEEF with in_last=1 -> writes (0,0xDEADBEEF), (1,0); then done=1, elem_count=1.
REQ-034 ADDR_W=3 with elements 1 to 5 and in_last never set -> writes end with (6,4), (7,0); then done=1, full=1, elem_count=4, in_ready=0, and element 5 is not accepted.
REQ-035 in_valid toggled 1,0,0,1 across two elements -> in_ready stays high through the gap with no writes during it, and the pointer for the first element is 2.
REQ-036 Reset during WR_DATA of element 2 -> wr_en=0 from the next cycle, state IDLE, elem_count=0; a following start rebuilds from address 0.
REQ-037 start pulsed during WR_PTR -> ignored, and the list completes normally.

Source files
------------

// File: rtl/list_builder_if.sv
// Producer stream, block-RAM write port and list status for list_builder.
interface list_builder_if #(
   parameter int unsigned ADDR_W = 10
);
   logic              start;
   logic              in_valid;
   logic [31:0]       in_data;
   logic              in_last;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_din;
   logic              done;
   logic              full;
   logic [ADDR_W-1:0] elem_count;

   modport master (
      output start, in_valid, in_data, in_last,
      input  in_ready, wr_en, ram_addr, ram_din, done, full, elem_count
   );

   modport slave (
      input  start, in_valid, in_data, in_last,
      output in_ready, wr_en, ram_addr, ram_din, done, full, elem_count
   );
endinterface

// File: rtl/list_builder.sv
// Builds a singly linked list in block RAM from a valid/ready element stream.
// Element k: data at 2k, next-pointer at 2k+1; the last pointer is 0.
module list_builder #(
   parameter int unsigned ADDR_W = 10
) (
   input logic          clk,
   input logic          rst,
   list_builder_if.slave bus
);
   localparam int unsigned K_W = ADDR_W - 1;
   localparam logic [K_W-1:0] K_MAX = '1;

   typedef enum logic [2:0] {
      IDLE,
      ACCEPT,
      WR_DATA,
      WR_PTR,
      DONE
   } state_t;

   state_t            state;
   logic [K_W-1:0]    k;
   logic              last_q;
   logic              terminal_c;
   logic [ADDR_W-1:0] next_ptr_c;

   // An element closes the list on in_last or when it fills the last slot.
   assign terminal_c = last_q || (k == K_MAX);
   assign next_ptr_c = {k, 1'b0} + ADDR_W'(2);

   // Outputs are set on the transition into the state that presents them.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state          <= IDLE;
         k              <= '0;
         last_q         <= 1'b0;
         bus.in_ready   <= 1'b0;
         bus.wr_en      <= 1'b0;
         bus.ram_addr   <= '0;
         bus.ram_din    <= '0;
         bus.done       <= 1'b0;
         bus.full       <= 1'b0;
         bus.elem_count <= '0;
      end else begin
         bus.wr_en <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state          <= ACCEPT;
                  k              <= '0;
                  bus.elem_count <= '0;
                  bus.done       <= 1'b0;
                  bus.full       <= 1'b0;
                  bus.in_ready   <= 1'b1;
               end
            end
            ACCEPT: begin
               if (bus.in_valid) begin
                  state        <= WR_DATA;
                  last_q       <= bus.in_last;
                  bus.in_ready <= 1'b0;
                  bus.wr_en    <= 1'b1;
                  bus.ram_addr <= {k, 1'b0};
                  bus.ram_din  <= bus.in_data;
               end
            end
            WR_DATA: begin
               state        <= WR_PTR;
               bus.wr_en    <= 1'b1;
               bus.ram_addr <= {k, 1'b1};
               bus.ram_din  <= terminal_c ? 32'd0 : 32'(next_ptr_c);
            end
            WR_PTR: begin
               bus.elem_count <= bus.elem_count + ADDR_W'(1);
               if (terminal_c) begin
                  state    <= DONE;
                  bus.done <= 1'b1;
                  bus.full <= ~last_q;
               end else begin
                  state        <= ACCEPT;
                  k            <= k + K_W'(1);
                  bus.in_ready <= 1'b1;
               end
            end
            default: begin
               state        <= IDLE;
               bus.in_ready <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_list_builder.sv
// Directed bench for list_builder: a table of list elements with expected
// RAM writes, plus hand sequences for gaps, reset, and capacity truncation.
module tb_list_builder;
   logic clk;
   logic rst;

   list_builder_if #(.ADDR_W(10)) b ();
   list_builder_if #(.ADDR_W(3))  s ();

   list_builder #(.ADDR_W(10)) dut (.clk(clk), .rst(rst), .bus(b));
   list_builder #(.ADDR_W(3))  dut_s (.clk(clk), .rst(rst), .bus(s));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;
   int s_wr_cnt = 0;

   always @(posedge clk) if (s.wr_en) s_wr_cnt <= s_wr_cnt + 1;

   typedef struct {
      logic        new_list;
      logic        start_ptr;
      logic [31:0] data;
      logic        last;
      logic [31:0] a_d;
      logic [31:0] a_p;
      logic [31:0] d_p;
      logic [31:0] exp_cnt;
      logic        exp_done;
      logic        exp_full;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Called on a negedge with the DUT in ACCEPT (or IDLE/DONE if new_list).
   task automatic feed(input vec_t v);
      if (v.new_list) begin
         b.start = 1'b1;
         @(negedge clk);
         b.start = 1'b0;
         chk("start_count", 32'(b.elem_count), 32'd0);
         chk("start_done", 32'(b.done), 32'd0);
      end
      b.in_valid = 1'b1;
      b.in_data  = v.data;
      b.in_last  = v.last;
      chk("accept_ready", 32'(b.in_ready), 32'd1);
      chk("accept_wr_en", 32'(b.wr_en), 32'd0);
      @(negedge clk);
      b.in_valid = 1'b0;
      b.in_data  = $urandom;
      b.in_last  = 1'($urandom);
      chk("wd_wr_en", 32'(b.wr_en), 32'd1);
      chk("wd_addr", 32'(b.ram_addr), v.a_d);
      chk("wd_din", b.ram_din, v.data);
      chk("wd_ready", 32'(b.in_ready), 32'd0);
      @(negedge clk);
      if (v.start_ptr) b.start = 1'b1;
      chk("wp_wr_en", 32'(b.wr_en), 32'd1);
      chk("wp_addr", 32'(b.ram_addr), v.a_p);
      chk("wp_din", b.ram_din, v.d_p);
      @(negedge clk);
      b.start = 1'b0;
      chk("count", 32'(b.elem_count), v.exp_cnt);
      chk("done", 32'(b.done), 32'(v.exp_done));
      chk("full", 32'(b.full), 32'(v.exp_full));
   endtask

   initial begin
      int n;
      //        new st  data          last a_d a_p d_p cnt done full
      tbl[0] = '{1'b1, 1'b0, 32'd5,        1'b0, 0, 1, 2, 1, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 32'd7,        1'b0, 2, 3, 4, 2, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 32'd9,        1'b1, 4, 5, 0, 3, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 0, 1, 0, 1, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 32'h11,       1'b0, 0, 1, 2, 1, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 32'h22,       1'b0, 2, 3, 4, 2, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 32'h33,       1'b0, 4, 5, 6, 3, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 1'b0, 32'h44,       1'b1, 6, 7, 0, 4, 1'b1, 1'b0};

      rst = 1'b0;
      b.start = 1'b0; b.in_valid = 1'b0; b.in_data = '0; b.in_last = 1'b0;
      s.start = 1'b0; s.in_valid = 1'b0; s.in_data = '0; s.in_last = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(b.in_ready), 32'd0);
      chk("rst_wr_en", 32'(b.wr_en), 32'd0);
      chk("rst_done", 32'(b.done), 32'd0);
      chk("rst_full", 32'(b.full), 32'd0);
      chk("rst_count", 32'(b.elem_count), 32'd0);
      chk("rst_s_ready", 32'(s.in_ready), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) feed(tbl[i]);

      // Valid gap of two cycles between elements.
      feed('{1'b1, 1'b0, 32'hA, 1'b0, 0, 1, 2, 1, 1'b0, 1'b0});
      for (int i = 0; i < 2; i++) begin
         chk("gap_ready", 32'(b.in_ready), 32'd1);
         chk("gap_wr_en", 32'(b.wr_en), 32'd0);
         @(negedge clk);
      end
      feed('{1'b0, 1'b0, 32'hB, 1'b1, 2, 3, 0, 2, 1'b1, 1'b0});

      // Reset (together with start) during WR_DATA of the second element.
      feed('{1'b1, 1'b0, 32'h50, 1'b0, 0, 1, 2, 1, 1'b0, 1'b0});
      b.in_valid = 1'b1; b.in_data = 32'h60; b.in_last = 1'b0;
      @(negedge clk);
      b.in_valid = 1'b0;
      chk("rs_wd_wr_en", 32'(b.wr_en), 32'd1);
      chk("rs_wd_addr", 32'(b.ram_addr), 32'd2);
      rst = 1'b0;
      b.start = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      b.start = 1'b0;
      chk("rs_wr_en", 32'(b.wr_en), 32'd0);
      chk("rs_ready", 32'(b.in_ready), 32'd0);
      chk("rs_count", 32'(b.elem_count), 32'd0);
      chk("rs_done", 32'(b.done), 32'd0);
      @(negedge clk);
      chk("rs_idle_wr_en", 32'(b.wr_en), 32'd0);
      chk("rs_idle_ready", 32'(b.in_ready), 32'd0);
      feed('{1'b1, 1'b0, 32'h70, 1'b1, 0, 1, 0, 1, 1'b1, 1'b0});

      // Capacity 4 list on the small instance, in_last never set.
      s.start = 1'b1;
      @(negedge clk);
      s.start = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         s.in_valid = 1'b1; s.in_data = 32'(i); s.in_last = 1'b0;
         chk("s_ready", 32'(s.in_ready), 32'd1);
         @(negedge clk);
         chk("s_wd_wr_en", 32'(s.wr_en), 32'd1);
         chk("s_wd_addr", 32'(s.ram_addr), 32'(2 * (i - 1)));
         chk("s_wd_din", s.ram_din, 32'(i));
         @(negedge clk);
         chk("s_wp_wr_en", 32'(s.wr_en), 32'd1);
         chk("s_wp_addr", 32'(s.ram_addr), 32'(2 * i - 1));
         chk("s_wp_din", s.ram_din, (i == 4) ? 32'd0 : 32'(2 * i));
         s.in_data = 32'd5;
         @(negedge clk);
      end
      chk("s_done", 32'(s.done), 32'd1);
      chk("s_full", 32'(s.full), 32'd1);
      chk("s_count", 32'(s.elem_count), 32'd4);
      chk("s_ready_done", 32'(s.in_ready), 32'd0);
      n = s_wr_cnt;
      repeat (5) begin
         @(negedge clk);
         chk("s_hold_ready", 32'(s.in_ready), 32'd0);
      end
      chk("s_no_extra_write", 32'(s_wr_cnt), 32'(n));
      chk("s_hold_full", 32'(s.full), 32'd1);
      s.in_valid = 1'b0;
      s.start = 1'b1;
      @(negedge clk);
      s.start = 1'b0;
      chk("s_restart_full", 32'(s.full), 32'd0);
      chk("s_restart_done", 32'(s.done), 32'd0);
      chk("s_restart_count", 32'(s.elem_count), 32'd0);
      chk("s_restart_ready", 32'(s.in_ready), 32'd1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
